// File: rtl/ipv4_pkg.sv
// rtl/ipv4_pkg.sv - shared IPv4 constants, header word indices and FSM state type
package ipv4_pkg;

  localparam logic [3:0] IP_VERSION = 4'd4;
  localparam logic [3:0] IHL_MIN    = 4'd5;

  localparam logic [7:0] PROTO_UDP  = 8'd17;

  // Header word indices (16-bit network words from the first header byte)
  localparam logic [4:0] W_VER_IHL   = 5'd0;
  localparam logic [4:0] W_TOT_LEN   = 5'd1;
  localparam logic [4:0] W_ID        = 5'd2;
  localparam logic [4:0] W_FRAG      = 5'd3;
  localparam logic [4:0] W_TTL_PROTO = 5'd4;
  localparam logic [4:0] W_CSUM      = 5'd5;
  localparam logic [4:0] W_SRC_HI    = 5'd6;
  localparam logic [4:0] W_SRC_LO    = 5'd7;
  localparam logic [4:0] W_DST_HI    = 5'd8;
  localparam logic [4:0] W_DST_LO    = 5'd9;

  // Bit position of the more-fragments flag inside the flags/frag_off word
  localparam int MF_BIT = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_OPT,
    ST_CHECK,
    ST_DATA,
    ST_DROP
  } ipv4_state_e;

  // Stream beats carry the earlier byte in [7:0]; header fields are big-endian
  function automatic logic [15:0] net_word(input logic [15:0] data);
    return {data[7:0], data[15:8]};
  endfunction

endpackage

// File: rtl/ipv4_head_rx_if.sv
// rtl/ipv4_head_rx_if.sv - byte stream in, header results and payload stream out
interface ipv4_head_rx_if #(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  logic                  valid_i;
  logic                  start_i;
  logic                  last_i;
  logic [DATA_W-1:0]     data_i;
  logic [DATA_W/8-1:0]   keep_i;

  logic                  head_valid_o;
  logic                  head_err_o;
  logic [ADDR_W-1:0]     src_addr_o;
  logic [ADDR_W-1:0]     dst_addr_o;
  logic [7:0]            protocol_o;
  logic [LEN_W-1:0]      pl_len_o;
  logic                  pl_valid_o;
  logic                  pl_start_o;
  logic                  pl_last_o;
  logic [DATA_W/8-1:0]   pl_keep_o;
  logic [DATA_W-1:0]     pl_data_o;
  logic                  pl_err_o;

  modport master (
    output valid_i, start_i, last_i, data_i, keep_i,
    input  head_valid_o, head_err_o, src_addr_o, dst_addr_o, protocol_o, pl_len_o,
    input  pl_valid_o, pl_start_o, pl_last_o, pl_keep_o, pl_data_o, pl_err_o
  );

  modport slave (
    input  valid_i, start_i, last_i, data_i, keep_i,
    output head_valid_o, head_err_o, src_addr_o, dst_addr_o, protocol_o, pl_len_o,
    output pl_valid_o, pl_start_o, pl_last_o, pl_keep_o, pl_data_o, pl_err_o
  );
endinterface

// File: rtl/ipv4_cs_acc.sv
// rtl/ipv4_cs_acc.sv - 16-bit ones-complement checksum accumulator
module ipv4_cs_acc (
  input  logic        clk,
  input  logic        nreset,
  input  logic        init,
  input  logic        add,
  input  logic [15:0] word,
  output logic [15:0] result
);
  logic [15:0] acc;
  logic [15:0] base;
  logic [16:0] total;
  logic [15:0] folded;

  // Sum including the current word, end-around carry folded back in
  always_comb begin
    base   = init ? 16'd0 : acc;
    total  = {1'b0, base} + {1'b0, word};
    folded = total[15:0] + {15'd0, total[16]};
  end

  assign result = folded;

  // Accumulator restarts on init and advances on every header word
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc <= 16'd0;
    end else if (init || add) begin
      acc <= folded;
    end
  end
endmodule

// File: rtl/ipv4_head_rx.sv
// rtl/ipv4_head_rx.sv - IPv4 receive header parser and payload stripper
module ipv4_head_rx
  import ipv4_pkg::*;
#(
  parameter int                LEN_W     = 16,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] DST_ADDR  = {8'd206, 8'd200, 8'd127, 8'd128},
  parameter logic [7:0]        PROTOCOL  = PROTO_UDP,
  parameter bit                CHECK_DST = 1'b1
) (
  input  logic          clk,
  input  logic          nreset,
  ipv4_head_rx_if.slave bus
);
  localparam int BYTES = DATA_W / 8;

  ipv4_state_e      state;
  // Wide enough for the last option word at IHL=15 (index 29)
  logic [4:0]       wcnt;
  logic [3:0]       ver_q;
  logic [3:0]       ihl_q;
  logic [15:0]      tot_len_q;
  logic [13:0]      frag_q;
  logic [7:0]       proto_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] byte_cnt;

  logic              head_valid;
  logic              head_err;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [7:0]        protocol;
  logic [LEN_W-1:0]  pl_len;
  logic              pl_valid;
  logic              pl_start;
  logic              pl_last;
  logic [1:0]        pl_keep;
  logic [DATA_W-1:0] pl_data;
  logic              pl_err;

  logic [15:0]      w;
  logic [15:0]      cs_result;
  logic [15:0]      hlen;
  logic [4:0]       hdr_end;
  logic [31:0]      dst_now;
  logic [LEN_W-1:0] pl_len_calc;
  logic [LEN_W-1:0] rem;
  logic             cs_init;
  logic             cs_add;
  logic             hdr_final;
  logic             hdr_err;

  assign w       = net_word(bus.data_i[15:0]);
  assign cs_init = bus.valid_i && bus.start_i;
  assign cs_add  = bus.valid_i && !bus.start_i && (state == ST_HEAD || state == ST_OPT);

  ipv4_cs_acc u_cs (
    .clk    (clk),
    .nreset (nreset),
    .init   (cs_init),
    .add    (cs_add),
    .word   (w),
    .result (cs_result)
  );

  // Header-complete detection and the validity decision on the final header beat
  always_comb begin
    hlen        = {10'd0, ihl_q, 2'b00};
    hdr_end     = {ihl_q, 1'b0} - 5'd1;
    dst_now     = (state == ST_HEAD) ? {dst_q[31:16], w} : dst_q;
    pl_len_calc = LEN_W'(tot_len_q - hlen);
    rem         = pl_len - byte_cnt;
    hdr_final   = 1'b0;
    if (state == ST_HEAD && wcnt == W_DST_LO && ihl_q <= IHL_MIN) hdr_final = 1'b1;
    if (state == ST_OPT && wcnt == hdr_end) hdr_final = 1'b1;
    hdr_err = (ver_q != IP_VERSION)
            | (ihl_q < IHL_MIN)
            | (cs_result != 16'hFFFF)
            | frag_q[MF_BIT]
            | (frag_q[12:0] != 13'd0)
            | (tot_len_q < hlen)
            | (proto_q != PROTOCOL)
            | (CHECK_DST && (ADDR_W'(dst_now) != DST_ADDR));
  end

  // Parser FSM with registered header results and payload stream
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      wcnt       <= 5'd0;
      ver_q      <= 4'd0;
      ihl_q      <= 4'd0;
      tot_len_q  <= 16'd0;
      frag_q     <= 14'd0;
      proto_q    <= 8'd0;
      src_q      <= 32'd0;
      dst_q      <= 32'd0;
      byte_cnt   <= '0;
      head_valid <= 1'b0;
      head_err   <= 1'b0;
      src_addr   <= '0;
      dst_addr   <= '0;
      protocol   <= 8'd0;
      pl_len     <= '0;
      pl_valid   <= 1'b0;
      pl_start   <= 1'b0;
      pl_last    <= 1'b0;
      pl_keep    <= 2'b00;
      pl_data    <= '0;
      pl_err     <= 1'b0;
    end else begin
      head_valid <= 1'b0;
      head_err   <= 1'b0;
      pl_valid   <= 1'b0;
      pl_start   <= 1'b0;
      pl_last    <= 1'b0;
      pl_err     <= 1'b0;
      if (bus.valid_i) begin
        if (bus.start_i) begin
          // A new packet always wins, aborting whatever was in flight
          if (state == ST_DATA) pl_err <= 1'b1;
          ver_q <= w[15:12];
          ihl_q <= w[11:8];
          wcnt  <= 5'd1;
          if (bus.last_i) begin
            head_valid <= 1'b1;
            head_err   <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            state <= ST_HEAD;
          end
        end else begin
          case (state)
            ST_HEAD, ST_OPT: begin
              wcnt <= wcnt + 5'd1;
              if (state == ST_HEAD) begin
                case (wcnt)
                  W_TOT_LEN:   tot_len_q       <= w;
                  W_FRAG:      frag_q          <= w[13:0];
                  W_TTL_PROTO: proto_q         <= w[7:0];
                  W_SRC_HI:    src_q[31:16]    <= w;
                  W_SRC_LO:    src_q[15:0]     <= w;
                  W_DST_HI:    dst_q[31:16]    <= w;
                  W_DST_LO:    dst_q[15:0]     <= w;
                  default: ;
                endcase
              end
              if (hdr_final) begin
                head_valid <= 1'b1;
                head_err   <= hdr_err;
                src_addr   <= ADDR_W'(src_q);
                dst_addr   <= ADDR_W'(dst_now);
                protocol   <= proto_q;
                pl_len     <= hdr_err ? '0 : pl_len_calc;
                byte_cnt   <= '0;
                if (bus.last_i) state <= ST_IDLE;
                else if (hdr_err || pl_len_calc == '0) state <= ST_DROP;
                else state <= ST_DATA;
              end else if (bus.last_i) begin
                head_valid <= 1'b1;
                head_err   <= 1'b1;
                state      <= ST_IDLE;
              end else if (state == ST_HEAD && wcnt == W_DST_LO) begin
                state <= ST_OPT;
              end
            end
            ST_DATA: begin
              pl_valid <= 1'b1;
              pl_data  <= bus.data_i;
              pl_start <= (byte_cnt == '0);
              byte_cnt <= byte_cnt + LEN_W'(BYTES);
              if (rem <= LEN_W'(2)) begin
                // Trim to tot_len; anything after is Ethernet padding
                pl_last <= 1'b1;
                pl_keep <= (rem == LEN_W'(1)) ? 2'b01 : 2'b11;
                state   <= bus.last_i ? ST_IDLE : ST_DROP;
              end else if (bus.last_i) begin
                pl_last <= 1'b1;
                pl_err  <= 1'b1;
                pl_keep <= bus.keep_i;
                state   <= ST_IDLE;
              end else begin
                pl_keep <= 2'b11;
              end
            end
            ST_DROP: begin
              if (bus.last_i) state <= ST_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.head_valid_o = head_valid;
  assign bus.head_err_o   = head_err;
  assign bus.src_addr_o   = src_addr;
  assign bus.dst_addr_o   = dst_addr;
  assign bus.protocol_o   = protocol;
  assign bus.pl_len_o     = pl_len;
  assign bus.pl_valid_o   = pl_valid;
  assign bus.pl_start_o   = pl_start;
  assign bus.pl_last_o    = pl_last;
  assign bus.pl_keep_o    = pl_keep;
  assign bus.pl_data_o    = pl_data;
  assign bus.pl_err_o     = pl_err;
endmodule

// File: tb/tb_ipv4_head_rx.sv
// tb/tb_ipv4_head_rx.sv - directed self-checking bench for ipv4_head_rx
module tb_ipv4_head_rx;
  logic clk = 1'b0;
  logic nreset = 1'b0;

  ipv4_head_rx_if bus ();

  ipv4_head_rx #(
    .DST_ADDR (32'hc0a800c7)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  bit [7:0]    fq[$];
  logic [15:0] hw[$];
  logic [15:0] pq[$];

  int cyc = 0;
  int n_hv, n_start, n_last, n_plerr, n_plerr_v;
  int hv_cyc, start_cyc, last_idx;
  logic herr_seen;
  logic [1:0] last_keep;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (bus.head_valid_o) begin
      n_hv++;
      herr_seen = bus.head_err_o;
      hv_cyc = cyc;
    end
    if (bus.pl_valid_o) begin
      pq.push_back(bus.pl_data_o);
      if (bus.pl_start_o) begin
        n_start++;
        start_cyc = cyc;
      end
      if (bus.pl_last_o) begin
        n_last++;
        last_keep = bus.pl_keep_o;
        last_idx = pq.size() - 1;
      end
    end
    if (bus.pl_err_o) begin
      n_plerr++;
      if (bus.pl_valid_o) n_plerr_v++;
    end
  end

  task automatic clr();
    pq.delete();
    n_hv = 0; n_start = 0; n_last = 0; n_plerr = 0; n_plerr_v = 0;
    hv_cyc = 0; start_cyc = 0; last_idx = -1; herr_seen = 1'bx; last_keep = 2'bxx;
  endtask

  task automatic push_hdr();
    foreach (hw[i]) begin
      fq.push_back(hw[i][15:8]);
      fq.push_back(hw[i][7:0]);
    end
  endtask

  task automatic push_pay(input int n, input bit [7:0] base);
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
  endtask

  task automatic mk_t1(input logic [15:0] cs);
    fq.delete();
    hw = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011, cs,
           16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7};
    push_hdr();
    push_pay(95, 8'h10);
  endtask

  task automatic mk_t4();
    fq.delete();
    hw = '{16'h4500, 16'h001c, 16'h0000, 16'h4000, 16'h4011, 16'hb8b8,
           16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7};
    push_hdr();
    push_pay(8, 8'h30);
    for (int i = 0; i < 32; i++) fq.push_back(8'hee);
  endtask

  task automatic send(input int gap, input bit do_last, input int nbeats);
    int n;
    int beats;
    n = fq.size();
    beats = (n + 1) / 2;
    if (nbeats > 0 && nbeats < beats) beats = nbeats;
    for (int k = 0; k < beats; k++) begin
      if (gap > 0 && k > 0 && (k % gap) == 0) begin
        @(posedge clk); #1;
        bus.valid_i = 1'b0; bus.start_i = 1'b0; bus.last_i = 1'b0;
      end
      @(posedge clk); #1;
      bus.valid_i = 1'b1;
      bus.start_i = (k == 0);
      bus.last_i  = do_last && (k == beats - 1);
      bus.data_i  = {(2*k+1 < n) ? fq[2*k+1] : 8'h00, fq[2*k]};
      bus.keep_i  = (2*k+1 < n) ? 2'b11 : 2'b01;
    end
    @(posedge clk); #1;
    bus.valid_i = 1'b0; bus.start_i = 1'b0; bus.last_i = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.start_i = 1'b0; bus.last_i = 1'b0;
    bus.data_i = 16'h0; bus.keep_i = 2'b00;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_head_valid", bus.head_valid_o, 0);
    chk("rst_pl_valid", bus.pl_valid_o, 0);
    chk("rst_pl_len", bus.pl_len_o, 0);
    chk("rst_src", bus.src_addr_o, 0);
    nreset = 1'b1;

    // good header, 95-byte payload
    clr(); mk_t1(16'hb861); send(0, 1, 0); drain();
    chk("t1_hv", n_hv, 1);
    chk("t1_err", herr_seen, 0);
    chk("t1_pl_len", bus.pl_len_o, 95);
    chk("t1_src", bus.src_addr_o, 32'hc0a80001);
    chk("t1_dst", bus.dst_addr_o, 32'hc0a800c7);
    chk("t1_proto", bus.protocol_o, 17);
    chk("t1_beats", pq.size(), 48);
    chk("t1_starts", n_start, 1);
    chk("t1_last_idx", last_idx, 47);
    chk("t1_keep", last_keep, 2'b01);
    chk("t1_first", pq.size() > 0 ? pq[0] : 16'hdead, 16'h1110);
    chk("t1_lastdata", pq.size() > 47 ? pq[47] : 16'hdead, 16'h006e);
    chk("t1_plerr", n_plerr, 0);
    chk("t1_order", hv_cyc < start_cyc, 1);

    // bad checksum: rejected, everything dropped
    clr(); mk_t1(16'hb862); send(0, 1, 0); drain();
    chk("t2_hv", n_hv, 1);
    chk("t2_err", herr_seen, 1);
    chk("t2_beats", pq.size(), 0);

    // IHL=6 with one option dword, stalls on every third beat
    clr(); fq.delete();
    hw = '{16'h4600, 16'h0020, 16'h0000, 16'h4000, 16'h4011, 16'hb3ae,
           16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7, 16'h0102, 16'h0304};
    push_hdr(); push_pay(8, 8'ha0);
    send(3, 1, 0); drain();
    chk("t3_err", herr_seen, 0);
    chk("t3_pl_len", bus.pl_len_o, 8);
    chk("t3_beats", pq.size(), 4);
    chk("t3_first", pq.size() > 0 ? pq[0] : 16'hdead, 16'ha1a0);
    chk("t3_keep", last_keep, 2'b11);

    // 60-byte padded frame with tot_len=28
    clr(); mk_t4(); send(0, 1, 0); drain();
    chk("t4_err", herr_seen, 0);
    chk("t4_beats", pq.size(), 4);
    chk("t4_last_idx", last_idx, 3);
    chk("t4_keep", last_keep, 2'b11);
    chk("t4_lastdata", pq.size() > 3 ? pq[3] : 16'hdead, 16'h3736);

    // frame ends at header word 6, then a normal frame
    clr(); mk_t1(16'hb861); send(0, 1, 7); drain();
    chk("t5_hv", n_hv, 1);
    chk("t5_err", herr_seen, 1);
    chk("t5_beats", pq.size(), 0);
    clr(); mk_t4(); send(0, 1, 0); drain();
    chk("t5_next_err", herr_seen, 0);
    chk("t5_next_beats", pq.size(), 4);

    // new start_i in the middle of the payload
    clr(); mk_t1(16'hb861); send(0, 0, 20);
    mk_t4(); send(0, 1, 0); drain();
    chk("t6_plerr", n_plerr, 1);
    chk("t6_plerr_valid", n_plerr_v, 0);
    chk("t6_hv", n_hv, 2);
    chk("t6_err", herr_seen, 0);
    chk("t6_beats", pq.size(), 14);
    chk("t6_lasts", n_last, 1);

    // asynchronous reset in the middle of the payload
    clr(); mk_t1(16'hb861); send(0, 0, 15);
    chk("t7_pre_valid", bus.pl_valid_o, 1);
    nreset = 1'b0;
    #1;
    chk("t7_pl_valid", bus.pl_valid_o, 0);
    chk("t7_pl_data", bus.pl_data_o, 0);
    chk("t7_pl_len", bus.pl_len_o, 0);
    chk("t7_src", bus.src_addr_o, 0);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    clr(); mk_t4(); send(0, 1, 0); drain();
    chk("t7_after_err", herr_seen, 0);
    chk("t7_after_beats", pq.size(), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
